// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: fetch-PC owner that issues one bundle request at a time and queues returned bundles for decode.
// Ports:
//   clk_i, rst_ni                  clock; asynchronous active-low reset
//   redirect_valid_i/redirect_pc_i flush queue, squash in-flight fetch, load new fetch PC
//   imem_req_valid_o/imem_req_addr_o  bundle request (memory always accepts)
//   imem_rsp_valid_i/imem_rsp_data_i  response for the single outstanding request
//   dec_valid_o/dec_ready_i        head-bundle handshake to decode
//   dec_inst_o/dec_pc_o/dec_pc_plus_4_o  head bundle contents
//   fq_count_o                     occupied queue entries
//   perf_fetch_cnt_o/perf_stall_cnt_o/perf_flush_cnt_o  only with IFU_PERF_CNT_EN defined
module ifu_fetch_queue #(
  parameter int unsigned FETCH_WIDTH     = 2,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter int unsigned FQ_DEPTH        = 4,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          redirect_valid_i,
  input  logic [INST_ADDR_WIDTH-1:0]    redirect_pc_i,
  output logic                          imem_req_valid_o,
  output logic [INST_ADDR_WIDTH-1:0]    imem_req_addr_o,
  input  logic                          imem_rsp_valid_i,
  input  logic [32*FETCH_WIDTH-1:0]     imem_rsp_data_i,
  output logic                          dec_valid_o,
  input  logic                          dec_ready_i,
  output logic [32*FETCH_WIDTH-1:0]     dec_inst_o,
  output logic [INST_ADDR_WIDTH-1:0]    dec_pc_o,
  output logic [INST_ADDR_WIDTH-1:0]    dec_pc_plus_4_o,
  output logic [$clog2(FQ_DEPTH):0]     fq_count_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_fetch_cnt_o,
  output logic [31:0]                   perf_stall_cnt_o,
  output logic [31:0]                   perf_flush_cnt_o
`endif
);
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = INST_ADDR_WIDTH;
  localparam int unsigned DW = 32 * FETCH_WIDTH;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d, req_pc_q;
  logic [DW-1:0] inst_q [FQ_DEPTH];
  logic [AW-1:0] pc_q [FQ_DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          issue, enq, deq;
  assign dec_valid_o      = cnt_q != '0;
  assign deq              = dec_valid_o & dec_ready_i & ~redirect_valid_i;
  // A same-cycle dequeue frees the slot this request will land in, so the check reserves space.
  // Gated by reset so the request line reads 0 while reset is held.
  assign issue            = rst_ni & (state_q == IDLE) & ((cnt_q != CW'(FQ_DEPTH)) | deq);
  assign enq              = (state_q == WAIT) & imem_rsp_valid_i & ~redirect_valid_i;
  assign imem_req_valid_o = issue;
  assign imem_req_addr_o  = fetch_pc_q;
  assign dec_inst_o       = inst_q[rd_q];
  assign dec_pc_o         = pc_q[rd_q];
  assign dec_pc_plus_4_o  = pc_q[rd_q] + AW'(4);
  assign fq_count_o       = cnt_q;
  // A redirect squashes anything in flight, including a request issued in this very cycle.
  always_comb begin
    state_d    = redirect_valid_i ? ((state_q == IDLE && !issue) ? IDLE : DROP) :
                 state_q == IDLE  ? (issue ? WAIT : IDLE) :
                 imem_rsp_valid_i ? IDLE : state_q;
    fetch_pc_d = redirect_valid_i ? (redirect_pc_i & ~AW'(3)) :
                 issue ? fetch_pc_q + AW'(4 * FETCH_WIDTH) : fetch_pc_q;
    cnt_d      = redirect_valid_i ? '0 : cnt_q + CW'(enq) - CW'(deq);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      rd_q       <= redirect_valid_i ? '0 : rd_q + PW'(deq);
      wr_q       <= redirect_valid_i ? '0 : wr_q + PW'(enq);
      if (issue) req_pc_q <= fetch_pc_q;
      if (enq) begin
        inst_q[wr_q] <= imem_rsp_data_i;
        pc_q[wr_q]   <= req_pc_q;
      end
    end
  end
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(enq && cnt_q == CW'(FQ_DEPTH)));
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(enq && fetch_cnt_q != '1);
      stall_cnt_q <= stall_cnt_q + 32'(dec_valid_o && !dec_ready_i && stall_cnt_q != '1);
      flush_cnt_q <= flush_cnt_q + 32'(redirect_valid_i && flush_cnt_q != '1);
    end
  end
  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif
endmodule
